output_port_scheduler: RTL

//   Round-robin scheduler for one router output port shared by NUM_REQ input requesters.

---
 rtl/output_port_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/output_port_scheduler.sv
// Round-robin, credit-gated scheduler for one router output port with optional packet locking.
// Define SCHED_PKT_LOCK_EN to hold a grant from head to tail; otherwise arbitration is per flit.
module output_port_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int CREDIT_W    = 3,
    parameter int MAX_CREDITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  tail,
    input  logic                credit_return,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                send_out,
    output logic [CREDIT_W-1:0] credits,
    output logic                credit_ovf
);

    localparam logic [CREDIT_W-1:0] MAXC = CREDIT_W'(MAX_CREDITS);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t              r_state, w_state_next;
    logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_next;
    logic [IDX_W-1:0]    r_owner, w_owner_next;
    logic [CREDIT_W-1:0] r_credits, w_credits_next;
    logic                r_ovf, w_ovf_next;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_found;
    logic                w_send;
    logic                w_is_tail;

    // Two passes give the rotating priority: indices at/after rr_ptr first, then the wrapped ones.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (!reset && r_credits != '0) begin
            if (r_state == S_LOCKED) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (int'(r_owner) == i && req[i]) begin
                        w_grant[i] = 1'b1;
                        w_idx      = IDX_W'(i);
                    end
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && req[i] && i >= int'(r_rr_ptr)) begin
                        w_found    = 1'b1;
                        w_grant[i] = 1'b1;
                        w_idx      = IDX_W'(i);
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && req[i] && i < int'(r_rr_ptr)) begin
                        w_found    = 1'b1;
                        w_grant[i] = 1'b1;
                        w_idx      = IDX_W'(i);
                    end
                end
            end
        end
    end

    assign w_send    = |w_grant;
    assign w_idx_inc = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

`ifdef SCHED_PKT_LOCK_EN
    assign w_is_tail = |(w_grant & tail);
`else
    // Without locking every flit closes its own packet.
    logic w_unused_tail;
    assign w_is_tail     = 1'b1;
    assign w_unused_tail = ^tail;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_rr_ptr_next  = r_rr_ptr;
        w_owner_next   = r_owner;
        w_credits_next = r_credits;
        w_ovf_next     = r_ovf;
        if (w_send) begin
            if (w_is_tail) begin
                w_rr_ptr_next = w_idx_inc;
                w_state_next  = S_IDLE;
            end else begin
                w_owner_next = w_idx;
                w_state_next = S_LOCKED;
            end
        end
        unique case ({w_send, credit_return})
            2'b10: w_credits_next = r_credits - CREDIT_W'(1);
            2'b01: begin
                if (r_credits == MAXC) w_ovf_next = 1'b1;
                else                   w_credits_next = r_credits + CREDIT_W'(1);
            end
            default: w_credits_next = r_credits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_credits <= MAXC;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_owner   <= w_owner_next;
            r_credits <= w_credits_next;
            r_ovf     <= w_ovf_next;
        end
    end

    assign grant      = w_grant;
    assign grant_idx  = w_idx;
    assign send_out   = w_send;
    assign credits    = r_credits;
    assign credit_ovf = r_ovf;

endmodule
